// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and address type for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 16;

    typedef logic [$clog2(DEF_NREGS)-1:0] reg_addr_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Pending-write tracking, issue stall and write-back error flag.
//               Honours REGFILE_WB_BYPASS_EN (write-back releases stall early).
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int PC_IDX = NREGS - 1,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              iss_ready,
    output logic [NREGS-1:0]  busy,
    output logic              wb_err
);

    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_eff;
    logic             wb_err_q;
    logic             wb_err_d;
    logic             wr_ok;
    logic             set_ok;

    always_comb begin
        busy_eff = busy_q;
`ifdef REGFILE_WB_BYPASS_EN
        if (we) busy_eff[wa] = 1'b0;
`endif
        busy_eff[PC_IDX] = 1'b0;
        iss_ready = !(busy_eff[ra1] | busy_eff[ra2] | busy_eff[iss_dst]);

        wr_ok  = we && (wa != PC_A);
        set_ok = iss_valid && iss_ready && (iss_dst != PC_A);

        // Set is applied after clear so a same-index collision leaves the bit set.
        busy_d = busy_q;
        if (wr_ok)  busy_d[wa]      = 1'b0;
        if (set_ok) busy_d[iss_dst] = 1'b1;

        wb_err_d = wb_err_q | (wr_ok & ~busy_q[wa]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy   = busy_q;
    assign wb_err = wb_err_q;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Register file with PC alias and issue scoreboard.
//               Optional REGFILE_WB_BYPASS_EN forwards write-back data to reads.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int PC_IDX = NREGS - 1,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] pc_val,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              iss_ready,
    output logic [NREGS-1:0]  busy,
    output logic              wb_err
);

    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]           regs_q [NREGS];
    logic                        we_g;
    logic                        iss_valid_g;
    logic [1:0][ADDR_W-1:0]      ra_w;
    logic [1:0][DATA_W-1:0]      rd_w;

    assign we_g        = we & ~rst;
    assign iss_valid_g = iss_valid & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we && (wa != PC_A)) begin
            regs_q[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = regs_q[a];
`ifdef REGFILE_WB_BYPASS_EN
        if (we_g && (wa == a)) v = wd;
`endif
        if (a == PC_A) v = pc_val;
        return v;
    endfunction

    assign ra_w[0] = ra1;
    assign ra_w[1] = ra2;

    for (genvar p = 0; p < 2; p++) begin : g_rdport
        assign rd_w[p] = rd_sel(ra_w[p]);
    end

    assign rd1 = rd_w[0];
    assign rd2 = rd_w[1];

    rf_scoreboard #(
        .NREGS  (NREGS),
        .PC_IDX (PC_IDX),
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .ra1       (ra1),
        .ra2       (ra2),
        .we        (we_g),
        .wa        (wa),
        .iss_valid (iss_valid_g),
        .iss_dst   (iss_dst),
        .iss_ready (iss_ready),
        .busy      (busy),
        .wb_err    (wb_err)
    );

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Randomised and directed checks of regfile_scoreboard against
//               a behavioural model; second instance covers 32x64 geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int PC = 15;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra1 = '0, ra2 = '0, wa = '0, iss_dst = '0;
    logic [DW-1:0] rd1, rd2, pc_val = '0, wd = '0;
    logic          we = 1'b0, iss_valid = 1'b0, iss_ready, wb_err;
    logic [NR-1:0] busy;

    logic [4:0]    b_ra1 = '0, b_ra2 = '0, b_wa = '0, b_iss_dst = '0;
    logic [63:0]   b_rd1, b_rd2, b_pc_val = '0, b_wd = '0;
    logic          b_we = 1'b0, b_iss_valid = 1'b0, b_iss_ready, b_wb_err;
    logic [31:0]   b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    bit            m_err;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .NREGS(NR), .PC_IDX(PC)) u_dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .pc_val(pc_val), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
        .iss_dst(iss_dst), .iss_ready(iss_ready), .busy(busy), .wb_err(wb_err)
    );

    regfile_scoreboard #(.DATA_W(64), .NREGS(32), .PC_IDX(31)) u_dut64 (
        .clk(clk), .rst(rst), .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
        .pc_val(b_pc_val), .we(b_we), .wa(b_wa), .wd(b_wd), .iss_valid(b_iss_valid),
        .iss_dst(b_iss_dst), .iss_ready(b_iss_ready), .busy(b_busy), .wb_err(b_wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_pending(input int i);
        if (i == PC) return 1'b0;
        if (BYP && we && int'(wa) == i) return 1'b0;
        return m_busy[i];
    endfunction

    function automatic logic [DW-1:0] m_read(input int a);
        if (a == PC) return pc_val;
        if (BYP && !rst && we && int'(wa) == a) return wd;
        return m_regs[a];
    endfunction

    function automatic bit m_ready();
        return !(m_pending(int'(ra1)) || m_pending(int'(ra2)) || m_pending(int'(iss_dst)));
    endfunction

    function automatic logic [NR-1:0] m_busy_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
        chk("rd1", rd1, m_read(int'(ra1)));
        chk("rd2", rd2, m_read(int'(ra2)));
        if (!rst) chk("iss_ready", iss_ready, m_ready());
        chk("busy", busy, m_busy_vec());
        chk("wb_err", wb_err, m_err);
    endtask

    task automatic commit();
        bit rdy;
        rdy = m_ready();
        @(posedge clk);
        if (!rst) begin
            if (we && int'(wa) != PC) begin
                if (!m_busy[wa]) m_err = 1'b1;
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (iss_valid && rdy && int'(iss_dst) != PC) m_busy[iss_dst] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; iss_valid = 1'b0; ra1 = '0; ra2 = '0; iss_dst = '0; wa = '0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        we = 1'b1; wa = 4'd3; wd = 32'hAA; ra1 = 4'd3; iss_valid = 1'b1; iss_dst = 4'd4;
        m_clear();
        settle();
        chk("rst_rd1", rd1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        ra1 = 4'd3;
        settle();
        chk("post_rst_rd1", rd1, 0);
        chk("post_rst_busy", busy, 0);
        commit();
    endtask

    task automatic rand_cycle();
        int cand [$];
        ra1       = AW'($urandom_range(NR - 1));
        ra2       = AW'($urandom_range(NR - 1));
        pc_val    = $urandom;
        iss_valid = ($urandom_range(1) == 1);
        iss_dst   = AW'($urandom_range(NR - 1));
        we        = ($urandom_range(2) == 0);
        wd        = $urandom;
        for (int i = 0; i < NR; i++) if (m_busy[i]) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(9) < 8)
            wa = AW'(cand[$urandom_range(cand.size() - 1)]);
        else
            wa = AW'($urandom_range(NR - 1));
        settle();
        commit();
    endtask

    initial begin
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Issue to r5, then a dependent instruction stalls until r5 writes back.
        iss_valid = 1'b1; iss_dst = 4'd5;
        settle(); commit();
        ra1 = 4'd5; iss_dst = 4'd1;
        settle();
        chk("stall_rdy", iss_ready, 0);
        chk("busy5", busy[5], 1);
        commit();
        we = 1'b1; wa = 4'd5; wd = 32'h1234;
        settle();
        chk("wb_rdy", iss_ready, BYP);
        chk("wb_rd1", rd1, BYP ? 32'h1234 : 32'h0);
        commit();
        we = 1'b0; iss_valid = 1'b0; iss_dst = 4'd0;
        settle();
        chk("after_wb_rdy", iss_ready, 1);
        chk("after_wb_rd1", rd1, 32'h1234);
        commit();

        // PC alias reads and discarded PC writes.
        ra2 = 4'd15; pc_val = 32'h100; we = 1'b1; wa = 4'd15; wd = 32'hDEAD;
        settle();
        chk("pc_rd2", rd2, 32'h100);
        commit();
        we = 1'b0;
        settle();
        chk("pc_rd2_hold", rd2, 32'h100);
        chk("pc_err", wb_err, 0);
        chk("pc_busy", busy[15], 0);
        commit();

        // Same-cycle clear and set of r7.
        ra1 = 4'd0; ra2 = 4'd0; iss_valid = 1'b1; iss_dst = 4'd7;
        settle(); commit();
        we = 1'b1; wa = 4'd7; wd = 32'h77;
        settle();
        chk("setwin_rdy", iss_ready, BYP);
        commit();
        we = 1'b0; iss_valid = 1'b0;
        settle();
        chk("setwin_busy7", busy[7], BYP);
        commit();

        // Write-back to an idle register raises the sticky error.
        we = 1'b1; wa = 4'd2; wd = 32'h55;
        settle(); commit();
        we = 1'b0; ra1 = 4'd2;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("err_sticky", wb_err, 1);
            commit();
        end
        chk("err_rd1", rd1, 32'h55);
        do_reset();
        chk("err_cleared", wb_err, 0);

        // 32x64 instance: stall, write-back release and PC alias at wa=30/31.
        b_iss_valid = 1'b1; b_iss_dst = 5'd30;
        @(negedge clk); #1;
        chk("b_issue_rdy", b_iss_ready, 1);
        @(posedge clk); #1;
        b_ra1 = 5'd30; b_iss_dst = 5'd0;
        @(negedge clk); #1;
        chk("b_stall", b_iss_ready, 0);
        chk("b_busy30", b_busy[30], 1);
        @(posedge clk); #1;
        b_we = 1'b1; b_wa = 5'd30; b_wd = 64'hFFFF_0000_FFFF_0000; b_iss_valid = 1'b0;
        @(negedge clk); #1;
        chk("b_wb_rdy", b_iss_ready, BYP);
        chk("b_wb_rd1", b_rd1, BYP ? 64'hFFFF_0000_FFFF_0000 : 64'h0);
        @(posedge clk); #1;
        b_we = 1'b0;
        @(negedge clk); #1;
        chk("b_after_rdy", b_iss_ready, 1);
        chk("b_after_rd1", b_rd1, 64'hFFFF_0000_FFFF_0000);
        chk("b_busy", b_busy, 0);
        b_ra2 = 5'd31; b_pc_val = 64'h100; b_we = 1'b1; b_wa = 5'd31; b_wd = 64'hDEAD;
        @(negedge clk); #1;
        chk("b_pc_rd2", b_rd2, 64'h100);
        @(posedge clk); #1;
        b_we = 1'b0;
        @(negedge clk); #1;
        chk("b_pc_hold", b_rd2, 64'h100);
        chk("b_pc_err", b_wb_err, 0);
        chk("b_pc_busy", b_busy[31], 0);
        @(posedge clk); #1;

        // Random traffic with occasional mid-stream reset.
        for (int n = 0; n < 450; n++) begin
            if (n % 150 == 149) do_reset();
            else rand_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_scoreboard
`default_nettype wire
